// File: rtl/encoder_pr_sequencer_if.sv
// ----------------------------------------------------------------------------
// encoder_pr_sequencer_if
// Resolution-control bundle between a requester/PPR lookup (master side) and
// the encoder sequencer (slave side).
//   pr_req        4   requested PR code (held stable until accepted)
//   pr_req_valid  1   request valid
//   pr_req_ready  1   sequencer can take a request this cycle
//   pr_cur        4   active PR code, drives the PPR lookup input
//   ppr_max       10  lookup result for pr_cur (pulses per revolution - 1)
//   pr_done       1   one-cycle pulse after a new PR code takes effect
// ----------------------------------------------------------------------------
interface encoder_pr_sequencer_if;
  logic [3:0] pr_req;
  logic       pr_req_valid;
  logic       pr_req_ready;
  logic [3:0] pr_cur;
  logic [9:0] ppr_max;
  logic       pr_done;

  modport master (
    output pr_req, pr_req_valid, ppr_max,
    input  pr_req_ready, pr_cur, pr_done
  );

  modport slave (
    input  pr_req, pr_req_valid, ppr_max,
    output pr_req_ready, pr_cur, pr_done
  );
endinterface

// File: rtl/encoder_pr_sequencer.sv
// ----------------------------------------------------------------------------
// encoder_pr_sequencer
// Incremental-encoder emulator: produces quadrature A/B and index Z at a
// programmable step rate, and owns the PR resolution code fed to the PPR
// lookup. Resolution changes arrive over a valid/ready handshake and, while
// running, only take effect at the index so no revolution is ever truncated.
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   en         in   1 = step generator running
//   dir        in   1 = forward, 0 = reverse
//   speed_div  in   one step every speed_div+1 cycles
//   pif        --   request handshake, pr_cur / ppr_max lookup, pr_done
//   enc_a/b/z  out  quadrature A, B and index
//   pos        out  pulse position within the revolution, 0..ppr_max
// ----------------------------------------------------------------------------
module encoder_pr_sequencer #(
  parameter logic [3:0] RESET_PR = 4'd4,
  parameter int         DIV_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 dir,
  input  logic [DIV_W-1:0]     speed_div,
  encoder_pr_sequencer_if.slave pif,
  output logic                 enc_a,
  output logic                 enc_b,
  output logic                 enc_z,
  output logic [9:0]           pos
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       phase_q, phase_d;
  logic [9:0]       pos_q, pos_d;
  logic [3:0]       pr_cur_q, pr_cur_d;
  logic [3:0]       pr_next_q, pr_next_d;
  logic             pending_q, pending_d;
  logic             done_q, done_d;
  logic             enc_a_q, enc_b_q, enc_z_q;

  logic step_fire;
  logic accept;
  logic apply;

  // Step-rate divider
  assign step_fire = en && (div_q == speed_div);

  always_comb begin
    div_d = '0;
    if (en && !step_fire) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Handshake and apply decision. accept needs !pending and apply needs
  // pending, so the two can never coincide: a request accepted this cycle
  // applies at the earliest on the next one.
  assign accept = pif.pr_req_valid && !pending_q;
  assign apply  = pending_q &&
                  (!en || (pos_q == 10'd0 && phase_q == 2'd0 && !step_fire));

  always_comb begin
    phase_d   = phase_q;
    pos_d     = pos_q;
    pr_cur_d  = pr_cur_q;
    pr_next_d = pr_next_q;
    pending_d = pending_q;
    done_d    = 1'b0;

    if (apply) begin
      pr_cur_d  = pr_next_q;
      pos_d     = 10'd0;
      phase_d   = 2'd0;
      pending_d = 1'b0;
      done_d    = 1'b1;
    end else begin
      if (accept) begin
        pr_next_d = pif.pr_req;
        pending_d = 1'b1;
      end
      if (step_fire) begin
        if (dir) begin
          phase_d = phase_q + 2'd1;
          // >= (not ==) so a stale pos beyond a shrunken ppr_max still wraps
          if (phase_q == 2'd3) begin
            pos_d = (pos_q >= pif.ppr_max) ? 10'd0 : pos_q + 10'd1;
          end
        end else begin
          phase_d = phase_q - 2'd1;
          if (phase_q == 2'd0) begin
            pos_d = (pos_q == 10'd0) ? pif.ppr_max : pos_q - 10'd1;
          end
        end
      end
    end
  end

  // State and output registers; outputs come from next state so they move
  // in the same cycle as pos/phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      phase_q   <= 2'd0;
      pos_q     <= 10'd0;
      pr_cur_q  <= RESET_PR;
      pr_next_q <= RESET_PR;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      enc_a_q   <= 1'b0;
      enc_b_q   <= 1'b0;
      enc_z_q   <= 1'b0;
    end else begin
      div_q     <= div_d;
      phase_q   <= phase_d;
      pos_q     <= pos_d;
      pr_cur_q  <= pr_cur_d;
      pr_next_q <= pr_next_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      enc_a_q   <= phase_d[1];
      enc_b_q   <= phase_d[1] ^ phase_d[0];
      enc_z_q   <= (pos_d == 10'd0) && (phase_d == 2'd0);
    end
  end

  assign pif.pr_req_ready = !pending_q;
  assign pif.pr_cur       = pr_cur_q;
  assign pif.pr_done      = done_q;
  assign enc_a            = enc_a_q;
  assign enc_b            = enc_b_q;
  assign enc_z            = enc_z_q;
  assign pos              = pos_q;

endmodule

// File: tb/tb_encoder_pr_sequencer.sv
module tb_encoder_pr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        dir;
  logic [15:0] speed_div;
  logic        enc_a, enc_b, enc_z;
  logic [9:0]  pos;

  int n_checks = 0;
  int n_err    = 0;

  encoder_pr_sequencer_if pif ();

  encoder_pr_sequencer #(.RESET_PR(4'd4), .DIV_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .dir       (dir),
    .speed_div (speed_div),
    .pif       (pif),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .enc_z     (enc_z),
    .pos       (pos)
  );

  always #5 clk = ~clk;

  // PPR lookup model (pulses per revolution minus one)
  function automatic logic [9:0] lut(input logic [3:0] code);
    case (code)
      4'd0:    return 10'd63;
      4'd4:    return 10'd255;
      4'd9:    return 10'd511;
      4'd15:   return 10'd1023;
      default: return 10'd127;
    endcase
  endfunction

  assign pif.ppr_max = lut(pif.pr_cur);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    dir = 1'b1;
    speed_div = 16'd0;
    pif.pr_req = 4'd0;
    pif.pr_req_valid = 1'b0;

    // ---- reset values
    #12;
    chk("rst_pr_cur", 32'(pif.pr_cur), 32'd4);
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_ab", 32'({enc_a, enc_b}), 32'd0);
    chk("rst_z", 32'(enc_z), 32'd0);
    chk("rst_ready", 32'(pif.pr_req_ready), 32'd1);
    chk("rst_done", 32'(pif.pr_done), 32'd0);
    reset = 1'b0;

    // ---- forward, step every cycle, PR 4 (256 pulses)
    en = 1'b1; dir = 1'b1; speed_div = 16'd0;
    tick(); chk("fwd_ab1", 32'({enc_a, enc_b}), 32'b01);
    tick(); chk("fwd_ab2", 32'({enc_a, enc_b}), 32'b11);
    tick(); chk("fwd_ab3", 32'({enc_a, enc_b}), 32'b10);
    tick(); chk("fwd_ab4", 32'({enc_a, enc_b}), 32'b00);
    chk("fwd_pos1", 32'(pos), 32'd1);
    chk("fwd_z_off", 32'(enc_z), 32'd0);
    repeat (1020) tick();
    chk("fwd_pos_wrap", 32'(pos), 32'd0);
    chk("fwd_z_on", 32'(enc_z), 32'd1);
    en = 1'b0;

    // ---- reverse, speed_div=3 from reset
    reset = 1'b1; #1; reset = 1'b0;
    en = 1'b1; dir = 1'b0; speed_div = 16'd3;
    repeat (3) tick();
    chk("rev_wait_pos", 32'(pos), 32'd0);
    chk("rev_wait_ab", 32'({enc_a, enc_b}), 32'b00);
    chk("rev_wait_z", 32'(enc_z), 32'd1);
    tick();
    chk("rev_ab", 32'({enc_a, enc_b}), 32'b10);
    chk("rev_pos", 32'(pos), 32'd255);
    chk("rev_z", 32'(enc_z), 32'd0);
    en = 1'b0;

    // ---- running request: PR 4 -> 0, applied at index
    reset = 1'b1; #1; reset = 1'b0;
    en = 1'b1; dir = 1'b1; speed_div = 16'd2;
    repeat (1200) tick();
    chk("run_pos100", 32'(pos), 32'd100);
    pif.pr_req = 4'd0; pif.pr_req_valid = 1'b1;
    tick();
    pif.pr_req_valid = 1'b0;
    chk("run_ready_low", 32'(pif.pr_req_ready), 32'd0);
    chk("run_pr_hold", 32'(pif.pr_cur), 32'd4);
    for (int i = 0; i < 3000 && pif.pr_done !== 1'b1; i++) tick();
    chk("run_done_seen", 32'(pif.pr_done), 32'd1);
    chk("run_pr_new", 32'(pif.pr_cur), 32'd0);
    chk("run_apply_pos", 32'(pos), 32'd0);
    chk("run_apply_z", 32'(enc_z), 32'd1);
    tick();
    chk("run_done_once", 32'(pif.pr_done), 32'd0);
    chk("run_ready_back", 32'(pif.pr_req_ready), 32'd1);
    repeat (763) tick();
    chk("run_rev_end_pos", 32'(pos), 32'd63);
    chk("run_rev_end_ab", 32'({enc_a, enc_b}), 32'b10);
    chk("run_rev_end_z", 32'(enc_z), 32'd0);
    repeat (3) tick();
    chk("run_rev64_pos", 32'(pos), 32'd0);
    chk("run_rev64_z", 32'(enc_z), 32'd1);
    en = 1'b0;

    // ---- stopped request: PR 15 applied immediately, realigns to index
    reset = 1'b1; #1; reset = 1'b0;
    en = 1'b1; dir = 1'b1; speed_div = 16'd0;
    repeat (150) tick();
    en = 1'b0;
    chk("stop_pos37", 32'(pos), 32'd37);
    chk("stop_ab", 32'({enc_a, enc_b}), 32'b11);
    pif.pr_req = 4'd15; pif.pr_req_valid = 1'b1;
    tick();
    pif.pr_req_valid = 1'b0;
    chk("stop_ready_low", 32'(pif.pr_req_ready), 32'd0);
    chk("stop_pr_hold", 32'(pif.pr_cur), 32'd4);
    tick();
    chk("stop_pr_new", 32'(pif.pr_cur), 32'd15);
    chk("stop_pos0", 32'(pos), 32'd0);
    chk("stop_z", 32'(enc_z), 32'd1);
    chk("stop_ab0", 32'({enc_a, enc_b}), 32'b00);
    chk("stop_done", 32'(pif.pr_done), 32'd1);
    tick();
    chk("stop_done_once", 32'(pif.pr_done), 32'd0);
    chk("stop_ready_back", 32'(pif.pr_req_ready), 32'd1);

    // ---- pending request discarded by async reset
    en = 1'b1; speed_div = 16'd0;
    pif.pr_req = 4'd9; pif.pr_req_valid = 1'b1;
    tick();
    pif.pr_req_valid = 1'b0;
    chk("pend_ready_low", 32'(pif.pr_req_ready), 32'd0);
    repeat (5) tick();
    chk("pend_pr_hold", 32'(pif.pr_cur), 32'd15);
    #2 reset = 1'b1;
    #1;
    chk("arst_pr_cur", 32'(pif.pr_cur), 32'd4);
    chk("arst_pos", 32'(pos), 32'd0);
    chk("arst_abz", 32'({enc_a, enc_b, enc_z}), 32'd0);
    chk("arst_ready", 32'(pif.pr_req_ready), 32'd1);
    chk("arst_done", 32'(pif.pr_done), 32'd0);
    en = 1'b0;
    #3 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_no_done", 32'(pif.pr_done), 32'd0);
    end
    chk("arst_pr_kept", 32'(pif.pr_cur), 32'd4);
    chk("arst_ready_kept", 32'(pif.pr_req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
